tamper_ctrl: RTL
================

# tamper_ctrl

Armable controller that sits in line on the serial monitor path (serial data, start, enable). It passes the stream through with one cycle of latency, deserialises each framed byte, and compares it against a programmed trigger byte. On a match it XOR-corrupts the following byte with a programmed flip mask. It then either re-hunts or stops, depending on one-shot mode.

## Interface
Parameters:
- BYTE_W, 8, bits per byte; sets the width of the shift register, the match byte and the flip mask.
- HIT_W, 4, width of the saturating hit counter.

Ports:
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- serial_in_i  in  1  serial data, MSB first; valid when enable_i=1.
- start_i  in  1  first-bit marker; meaningful only when enable_i=1.
- enable_i  in  1  bit-valid / frame-active qualifier.
- arm_i  in  1  pulse; captures config and arms the block.
- disarm_i  in  1  pulse; aborts and returns to IDLE.
- one_shot_i  in  1  captured on arm; 1 = stop after one corruption.
- match_byte_i  in  BYTE_W  trigger byte; captured on arm.
- flip_mask_i  in  BYTE_W  XOR mask for the victim byte; captured on arm.
- serial_out_o  out  1  registered serial_in_i XOR the active flip bit.
- start_o  out  1  start_i delayed 1 cycle.
- enable_o  out  1  enable_i delayed 1 cycle.
- match_o  out  1  one-cycle pulse on each trigger match.
- corrupt_o  out  1  high while serial_out_o carries a corrupted-byte bit.
- armed_o  out  1  high in any state except IDLE.
- hit_count_o  out  HIT_W  number of completed corruptions; saturates at all-ones.

## Operation
- A bit is valid when enable_i=1.
- start_i=1 with enable_i=1 forces the bit index to 0. That bit is the first bit of a new byte and any partial byte is discarded.
- The bit index counts 0..BYTE_W-1 on valid bits and wraps to 0.
- The shift register shifts left, taking serial_in_i into the LSB.
- A byte is complete on the valid bit with index BYTE_W-1. Its value is {shift[BYTE_W-2:0], serial_in_i}.
- enable_i=0 ends the frame: bit index clears and the partial byte is dropped.

States:
- IDLE: pass-through only. arm_i -> ARMED.
- ARMED: waiting for a frame. Valid bit with start_i=1 -> HUNT; that bit is also processed as bit 0.
- HUNT: on each complete byte equal to the captured match byte, pulse match_o and go to CORRUPT.
- CORRUPT: each valid bit is XORed with mask[BYTE_W-1-index] before registering.
  - Byte complete, one_shot=1 -> DONE, hit_count +1.
  - Byte complete, one_shot=0 -> HUNT, hit_count +1.
  - start_i restart -> HUNT; no count, corruption abandoned.
- DONE: pass-through only. arm_i -> ARMED.
- Frame end: enable_i=0 in HUNT or CORRUPT -> ARMED, with no count.
- arm_i is ignored in HUNT and CORRUPT.
- disarm_i from any state -> IDLE. It wins over a simultaneous arm_i, match or byte completion.
- Arming captures match_byte_i, flip_mask_i and one_shot_i into registers, and clears hit_count_o.
- A trigger byte may itself be preceded by the victim of an earlier match: a corrupted byte is never compared for a match.

## Timing
- All outputs are registered. On reset they are serial_out_o=0, start_o=0, enable_o=0, match_o=0, corrupt_o=0, armed_o=0, hit_count_o=0. Reset also sets state IDLE, bit index 0, shift register 0, config registers 0.
- Data path latency is exactly 1 cycle: serial_out_o, start_o and enable_o at cycle N+1 reflect inputs at cycle N.
- match_o is high in the cycle after the last trigger bit, aligned with that bit's appearance on serial_out_o.
- corrupt_o is aligned with the corrupted bit on serial_out_o. It is high only for valid bits processed in CORRUPT.
- A mask of 0 still counts as a corruption; corrupt_o asserts and the data is unchanged.
- armed_o updates the cycle after the state changes.
- hit_count_o updates the cycle after the victim's last bit.
- Reset mid-byte: outputs drop to 0 immediately (asynchronously), and the stream resumes in IDLE after reset deasserts.

## Test plan
- Pass-through: IDLE, stream 0x3C framed -> serial_out_o equals the input delayed 1 cycle; match_o and corrupt_o stay 0.
- Basic hit: arm with match 0xA5, mask 0xFF, one_shot=1, frame A5 3C 11 -> output A5 C3 11; match_o pulses once; corrupt_o high 8 cycles; hit_count_o=1; state DONE (armed_o=1).
- Repeat mode: one_shot=0, match 0x55, mask 0x01, frame 55 00 55 55 00 -> output 55 01 55 54 00; hit_count_o=2. The second 55 is the victim and is not re-matched.
- Restart/abort: start_i re-asserted at bit 3 of the victim -> remaining bits uncorrupted, back to HUNT, hit_count_o unchanged. enable_i dropped mid-trigger -> ARMED, no match_o.
- Precedence: disarm_i and arm_i in the same cycle while in HUNT -> IDLE; config not recaptured.
- Saturation and reset: HIT_W=2, five hits in repeat mode -> hit_count_o=3. Assert rst_i mid-victim -> all outputs 0 in the same cycle; IDLE after release.

Source files
------------

// File: rtl/tamper_ctrl.sv
// In-line serial monitor tamper controller: passes the stream through with one
// cycle of latency and XOR-corrupts the byte following a programmed trigger byte.
module tamper_ctrl #(
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned HIT_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              serial_in_i,
    input  logic              start_i,
    input  logic              enable_i,
    input  logic              arm_i,
    input  logic              disarm_i,
    input  logic              one_shot_i,
    input  logic [BYTE_W-1:0] match_byte_i,
    input  logic [BYTE_W-1:0] flip_mask_i,
    output logic              serial_out_o,
    output logic              start_o,
    output logic              enable_o,
    output logic              match_o,
    output logic              corrupt_o,
    output logic              armed_o,
    output logic [HIT_W-1:0]  hit_count_o
);

    localparam int unsigned    IDX_W    = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_W - 1);
    localparam logic [HIT_W-1:0] HIT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HUNT,
        S_CORRUPT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [BYTE_W-1:0] match_q, match_d;
    logic [BYTE_W-1:0] mask_q, mask_d;
    logic              one_shot_q, one_shot_d;
    logic [HIT_W-1:0]  hits_q, hits_d;
    logic              ser_q, ser_d;
    logic              start_q, start_d;
    logic              en_q, en_d;
    logic              match_pulse_q, match_pulse_d;
    logic              corrupt_q, corrupt_d;
    logic              armed_q, armed_d;

    logic              restart;
    logic [IDX_W-1:0]  cur_idx;
    logic              byte_done;
    logic [BYTE_W-1:0] byte_val;
    logic              flip;
    logic              capture;

    // Bit framing, FSM and registered output values
    always_comb begin
        restart   = enable_i & start_i;
        cur_idx   = restart ? '0 : idx_q;
        byte_done = enable_i & (cur_idx == LAST_IDX);
        byte_val  = BYTE_W'({shift_q, serial_in_i});

        state_d       = state_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        match_d       = match_q;
        mask_d        = mask_q;
        one_shot_d    = one_shot_q;
        hits_d        = hits_q;
        match_pulse_d = 1'b0;
        corrupt_d     = 1'b0;
        flip          = 1'b0;
        capture       = 1'b0;

        if (!enable_i) begin
            idx_d = '0;
        end else begin
            idx_d   = byte_done ? '0 : cur_idx + IDX_W'(1);
            shift_d = byte_val;
        end

        if (disarm_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm_i) begin
                        state_d = S_ARMED;
                        capture = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (arm_i) begin
                        capture = 1'b1;
                    end else if (restart) begin
                        state_d = S_HUNT;
                    end
                end
                S_HUNT: begin
                    if (!enable_i) begin
                        state_d = S_ARMED;
                    end else if (byte_done && (byte_val == match_q)) begin
                        state_d       = S_CORRUPT;
                        match_pulse_d = 1'b1;
                    end
                end
                S_CORRUPT: begin
                    if (!enable_i) begin
                        state_d = S_ARMED;
                    end else if (restart) begin
                        state_d = S_HUNT;
                    end else begin
                        // Victim bits never feed the matcher; the next byte is hunted afresh
                        flip      = mask_q[LAST_IDX - cur_idx];
                        corrupt_d = 1'b1;
                        if (byte_done) begin
                            hits_d  = (hits_q == HIT_MAX) ? hits_q : hits_q + HIT_W'(1);
                            state_d = one_shot_q ? S_DONE : S_HUNT;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (capture) begin
            match_d    = match_byte_i;
            mask_d     = flip_mask_i;
            one_shot_d = one_shot_i;
            hits_d     = '0;
        end

        ser_d   = serial_in_i ^ flip;
        start_d = start_i;
        en_d    = enable_i;
        armed_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            shift_q       <= '0;
            match_q       <= '0;
            mask_q        <= '0;
            one_shot_q    <= 1'b0;
            hits_q        <= '0;
            ser_q         <= 1'b0;
            start_q       <= 1'b0;
            en_q          <= 1'b0;
            match_pulse_q <= 1'b0;
            corrupt_q     <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            match_q       <= match_d;
            mask_q        <= mask_d;
            one_shot_q    <= one_shot_d;
            hits_q        <= hits_d;
            ser_q         <= ser_d;
            start_q       <= start_d;
            en_q          <= en_d;
            match_pulse_q <= match_pulse_d;
            corrupt_q     <= corrupt_d;
            armed_q       <= armed_d;
        end
    end

    assign serial_out_o = ser_q;
    assign start_o      = start_q;
    assign enable_o     = en_q;
    assign match_o      = match_pulse_q;
    assign corrupt_o    = corrupt_q;
    assign armed_o      = armed_q;
    assign hit_count_o  = hits_q;

endmodule
